// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file for the simple MIPS core.
// Selects the write-back value, commits it, serves two bypassed read ports and
// keeps a per-register pending-write scoreboard for RAW hazard detection.
module wb_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] WB_Data_mem_out,
   input  logic [31:0] WB_ALU_out,
   input  logic [4:0]  WB_register_addr,
   input  logic        WB_MemtoReg,
   input  logic        WB_RegWrite,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic        squash_valid,
   input  logic [4:0]  squash_rd,
   output logic [31:0] wb_data,
   output logic        rs_pending,
   output logic        rt_pending,
   output logic        sb_error
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];
   logic [1:0]  cnt_q  [32];
   logic [1:0]  cnt_d  [32];
   logic        sb_error_q;
   logic        sb_error_d;
   logic        retire;

   // Write-back mux and commit qualifier (register 0 never commits)
   assign wb_data  = WB_MemtoReg ? WB_Data_mem_out : WB_ALU_out;
   assign retire   = WB_RegWrite && (WB_register_addr != 5'd0);
   assign sb_error = sb_error_q;

   // Next register-file contents: only the retiring destination changes
   always_comb begin
      regs_d = regs_q;
      if (retire) begin
         regs_d[WB_register_addr] = wb_data;
      end
   end

   // Scoreboard update: issue/squash/retire hits are summed, then clamped to 0..3
   always_comb begin : sb_next
      logic       inc;
      logic       dec_sq;
      logic       dec_rt;
      logic [2:0] up;
      logic [2:0] down;
      logic [2:0] res;
      cnt_d      = cnt_q;
      sb_error_d = sb_error_q;
      inc        = 1'b0;
      dec_sq     = 1'b0;
      dec_rt     = 1'b0;
      up         = 3'd0;
      down       = 3'd0;
      res        = 3'd0;
      // Register 0 is skipped entirely, so its counter stays at zero
      for (int r = 1; r < 32; r++) begin
         inc    = issue_valid  && (issue_rd == 5'(r));
         dec_sq = squash_valid && (squash_rd == 5'(r));
         dec_rt = retire       && (WB_register_addr == 5'(r));
         up     = {1'b0, cnt_q[r]} + {2'b00, inc};
         down   = {2'b00, dec_sq} + {2'b00, dec_rt};
         if (down > up) begin
            cnt_d[r]   = 2'd0;
            sb_error_d = 1'b1;
         end else begin
            res = up - down;
            if (res > 3'd3) begin
               cnt_d[r]   = 2'd3;
               sb_error_d = 1'b1;
            end else begin
               cnt_d[r] = res[1:0];
            end
         end
      end
   end

   // rs read port: $0 is hard zero, a same-cycle retire is bypassed
   always_comb begin
      rs_data = regs_q[rs_addr];
      if (rs_addr == 5'd0) begin
         rs_data = 32'd0;
      end else if (retire && (WB_register_addr == rs_addr)) begin
         rs_data = wb_data;
      end
   end

   // rt read port: identical to rs
   always_comb begin
      rt_data = regs_q[rt_addr];
      if (rt_addr == 5'd0) begin
         rt_data = 32'd0;
      end else if (retire && (WB_register_addr == rt_addr)) begin
         rt_data = wb_data;
      end
   end

   // Pending flags: a write retiring this cycle is already served by the bypass
   always_comb begin
      rs_pending = (rs_addr != 5'd0) &&
                   (cnt_q[rs_addr] > ((retire && (WB_register_addr == rs_addr)) ? 2'd1 : 2'd0));
      rt_pending = (rt_addr != 5'd0) &&
                   (cnt_q[rt_addr] > ((retire && (WB_register_addr == rt_addr)) ? 2'd1 : 2'd0));
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
            cnt_q[i]  <= 2'd0;
         end
         sb_error_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         cnt_q      <= cnt_d;
         sb_error_q <= sb_error_d;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic,
// compared against an integer-arithmetic reference model of the register file
// and scoreboard.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] WB_Data_mem_out;
   logic [31:0] WB_ALU_out;
   logic [4:0]  WB_register_addr;
   logic        WB_MemtoReg;
   logic        WB_RegWrite;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        squash_valid;
   logic [4:0]  squash_rd;
   logic [31:0] wb_data;
   logic        rs_pending;
   logic        rt_pending;
   logic        sb_error;

   int          n_assert = 0;
   int          n_fail   = 0;

   // Reference model state
   logic [31:0] reg_m [32];
   int          cnt_m [32];
   logic        err_m;

   // Free-running clock
   always #5 clk = ~clk;

   wb_regfile dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .WB_Data_mem_out  (WB_Data_mem_out),
      .WB_ALU_out       (WB_ALU_out),
      .WB_register_addr (WB_register_addr),
      .WB_MemtoReg      (WB_MemtoReg),
      .WB_RegWrite      (WB_RegWrite),
      .rs_addr          (rs_addr),
      .rt_addr          (rt_addr),
      .rs_data          (rs_data),
      .rt_data          (rt_data),
      .issue_valid      (issue_valid),
      .issue_rd         (issue_rd),
      .squash_valid     (squash_valid),
      .squash_rd        (squash_rd),
      .wb_data          (wb_data),
      .rs_pending       (rs_pending),
      .rt_pending       (rt_pending),
      .sb_error         (sb_error)
   );

   function automatic logic [31:0] wb_m();
      return WB_MemtoReg ? WB_Data_mem_out : WB_ALU_out;
   endfunction

   function automatic bit retire_m();
      return WB_RegWrite && (WB_register_addr != 5'd0);
   endfunction

   function automatic logic [31:0] read_m(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (retire_m() && (WB_register_addr == a)) return wb_m();
      return reg_m[a];
   endfunction

   function automatic logic pend_m(input logic [4:0] a);
      int thr;
      thr = (retire_m() && (WB_register_addr == a)) ? 1 : 0;
      return (a != 5'd0) && (cnt_m[a] > thr);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         reg_m[i] = 32'd0;
         cnt_m[i] = 0;
      end
      err_m = 1'b0;
   endtask

   // Apply the effects of one clock edge using the current inputs
   task automatic model_edge();
      int d;
      int raw;
      bit ret;
      ret = retire_m();
      if (ret) reg_m[WB_register_addr] = wb_m();
      for (int r = 1; r < 32; r++) begin
         d = 0;
         if (issue_valid && issue_rd == 5'(r)) d = d + 1;
         if (squash_valid && squash_rd == 5'(r)) d = d - 1;
         if (ret && WB_register_addr == 5'(r)) d = d - 1;
         raw = cnt_m[r] + d;
         if (raw < 0) begin
            cnt_m[r] = 0;
            err_m = 1'b1;
         end else if (raw > 3) begin
            cnt_m[r] = 3;
            err_m = 1'b1;
         end else begin
            cnt_m[r] = raw;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rs_data"},    rs_data,           read_m(rs_addr));
      chk({tag, ".rt_data"},    rt_data,           read_m(rt_addr));
      chk({tag, ".rs_pending"}, {31'd0, rs_pending}, {31'd0, pend_m(rs_addr)});
      chk({tag, ".rt_pending"}, {31'd0, rt_pending}, {31'd0, pend_m(rt_addr)});
      chk({tag, ".wb_data"},    wb_data,           wb_m());
      chk({tag, ".sb_error"},   {31'd0, sb_error}, {31'd0, err_m});
   endtask

   task automatic set_idle();
      WB_Data_mem_out  = 32'd0;
      WB_ALU_out       = 32'd0;
      WB_register_addr = 5'd0;
      WB_MemtoReg      = 1'b0;
      WB_RegWrite      = 1'b0;
      issue_valid      = 1'b0;
      issue_rd         = 5'd0;
      squash_valid     = 1'b0;
      squash_rd        = 5'd0;
   endtask

   // Let combinational outputs settle after the negedge drive, then compare
   task automatic settle(input string tag);
      #1;
      $display("[%0t] %s rs=%0d rt=%0d we=%0b wa=%0d iss=%0b/%0d sq=%0b/%0d wb=%h",
               $time, tag, rs_addr, rt_addr, WB_RegWrite, WB_register_addr,
               issue_valid, issue_rd, squash_valid, squash_rd, wb_data);
      check_all(tag);
   endtask

   // Take one clock edge in both DUT and model, return at the next negedge
   task automatic advance();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      set_idle();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // $0 protection: write, issue to register 0
      WB_RegWrite = 1'b1; WB_register_addr = 5'd0; WB_ALU_out = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_rd = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
      settle("zero_wr");
      chk("zero_rs_data", rs_data, 32'd0);
      chk("zero_rs_pend", {31'd0, rs_pending}, 32'd0);
      advance();
      set_idle();
      settle("zero_after");
      chk("zero_rs_after", rs_data, 32'd0);
      chk("zero_sb_error", {31'd0, sb_error}, 32'd0);

      // Scoreboard lifecycle on register 7
      issue_valid = 1'b1; issue_rd = 5'd7; rt_addr = 5'd7;
      settle("life_issue");
      chk("life_pend_c1", {31'd0, rt_pending}, 32'd0);
      advance();
      set_idle();
      settle("life_c2");
      chk("life_pend_c2", {31'd0, rt_pending}, 32'd1);
      advance();
      settle("life_c3");
      advance();
      WB_RegWrite = 1'b1; WB_register_addr = 5'd7; WB_ALU_out = 32'h0BAD_F00D;
      settle("life_retire");
      chk("life_pend_c4", {31'd0, rt_pending}, 32'd0);
      chk("life_data_c4", rt_data, 32'h0BAD_F00D);
      advance();
      set_idle();
      settle("life_after");
      chk("life_data_after", rt_data, 32'h0BAD_F00D);
      chk("life_sb_error", {31'd0, sb_error}, 32'd0);

      // Simultaneous issue/squash/retire on register 9 with count 1
      issue_valid = 1'b1; issue_rd = 5'd9; rs_addr = 5'd9;
      settle("sim_prep");
      advance();
      issue_valid = 1'b1; issue_rd = 5'd9; squash_valid = 1'b1; squash_rd = 5'd9;
      WB_RegWrite = 1'b1; WB_register_addr = 5'd9; WB_ALU_out = 32'h0000_0909;
      settle("sim_all3");
      chk("sim_pend_bypass", {31'd0, rs_pending}, 32'd0);
      advance();
      set_idle();
      settle("sim_after");
      chk("sim_pend_after", {31'd0, rs_pending}, 32'd0);
      chk("sim_sb_error", {31'd0, sb_error}, 32'd0);

      // Saturation: four issues to register 9 with no retire
      for (int k = 0; k < 4; k++) begin
         issue_valid = 1'b1; issue_rd = 5'd9;
         settle("sat_issue");
         advance();
      end
      set_idle();
      settle("sat_after");
      chk("sat_pend", {31'd0, rs_pending}, 32'd1);
      chk("sat_sb_error", {31'd0, sb_error}, 32'd1);

      // Asynchronous reset asserted mid-cycle
      #2;
      rst_n = 1'b0;
      model_reset();
      WB_ALU_out = 32'h5A5A_0001;
      for (int a = 0; a < 32; a++) begin
         rs_addr = 5'(a);
         rt_addr = 5'(31 - a);
         settle("rst_scan");
      end
      chk("rst_sb_error", {31'd0, sb_error}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_idle();

      // Underflow: retire to register 3 with nothing outstanding
      WB_RegWrite = 1'b1; WB_register_addr = 5'd3; WB_ALU_out = 32'hA5A5_3333; rs_addr = 5'd3;
      settle("uf_retire");
      chk("uf_err_before", {31'd0, sb_error}, 32'd0);
      advance();
      set_idle();
      for (int k = 0; k < 3; k++) begin
         settle("uf_hold");
         chk("uf_sb_error", {31'd0, sb_error}, 32'd1);
         chk("uf_data", rs_data, 32'hA5A5_3333);
         chk("uf_pend", {31'd0, rs_pending}, 32'd0);
         advance();
      end

      // Write/bypass with ALU source then load source
      WB_MemtoReg = 1'b0; WB_ALU_out = 32'hDEAD_BEEF; WB_Data_mem_out = 32'h1111_1111;
      WB_register_addr = 5'd5; WB_RegWrite = 1'b1; rs_addr = 5'd5;
      settle("wr_alu");
      chk("wr_alu_bypass", rs_data, 32'hDEAD_BEEF);
      advance();
      set_idle();
      settle("wr_alu_after");
      chk("wr_alu_reg", rs_data, 32'hDEAD_BEEF);
      WB_MemtoReg = 1'b1; WB_Data_mem_out = 32'h1234_5678; WB_ALU_out = 32'h2222_2222;
      WB_register_addr = 5'd5; WB_RegWrite = 1'b1; rt_addr = 5'd5;
      settle("wr_mem");
      chk("wr_mem_bypass", rt_data, 32'h1234_5678);
      advance();
      set_idle();
      settle("wr_mem_after");
      chk("wr_mem_reg", rt_data, 32'h1234_5678);

      // Randomized traffic, addresses biased to a small window to provoke hits
      for (int n = 0; n < 600; n++) begin
         WB_Data_mem_out  = $urandom;
         WB_ALU_out       = $urandom;
         WB_MemtoReg      = 1'($urandom_range(0, 1));
         WB_RegWrite      = ($urandom_range(0, 3) == 0);
         WB_register_addr = 5'($urandom_range(0, 7));
         issue_valid      = ($urandom_range(0, 2) == 0);
         issue_rd         = 5'($urandom_range(0, 7));
         squash_valid     = ($urandom_range(0, 7) == 0);
         squash_rd        = 5'($urandom_range(0, 7));
         rs_addr          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rt_addr          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         settle("rand");
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
